// File: rtl/hit_score_counter.sv
// Hit detector and saturating 4-digit BCD score: at most one hit per frame, then a frame-count cooldown.
// hit_pulse follows the start-of-frame that closes a hit frame by one cycle, and score_bcd updates one cycle later.
module hit_score_counter #(
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        collision,
  input  logic [31:0] pxl_x,
  input  logic [31:0] pxl_y,
  output logic [15:0] score_bcd,
  output logic        hit_pulse,
  output logic        saturated,
  output logic        armed
);

  typedef enum logic [1:0] {
    S_ARMED = 2'd0,
    S_INCR  = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  localparam logic [7:0]  COOL_INIT = COOLDOWN_FRAMES[7:0];
  localparam logic [15:0] SCORE_MAX = 16'h9999;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] score_q, score_d;
  logic        sat_q, sat_d;
  logic        hit_seen_q, hit_seen_d;
  logic        prev_origin_q, prev_origin_d;
  logic        origin;
  logic        sof;

  // Ripple the +1 through the digits; a 9 wraps to 0 and passes the carry on.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign origin = (pxl_x == 32'd0) && (pxl_y == 32'd0);
  assign sof    = origin && !prev_origin_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    score_d       = score_q;
    prev_origin_d = origin;
    hit_seen_d    = hit_seen_q;

    // A collision on the sof cycle itself belongs to the frame that is starting.
    if (sof) begin
      hit_seen_d = collision;
    end else if (collision) begin
      hit_seen_d = 1'b1;
    end

    case (state_q)
      S_ARMED: begin
        if (sof && hit_seen_q) begin
          state_d = S_INCR;
        end
      end
      S_INCR: begin
        cnt_d = COOL_INIT;
        if (score_q != SCORE_MAX) begin
          score_d = bcd_inc(score_q);
        end
        state_d = (COOLDOWN_FRAMES == 0) ? S_ARMED : S_COOL;
      end
      S_COOL: begin
        if (sof) begin
          if (cnt_q == 8'd1) begin
            state_d = S_ARMED;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = S_ARMED;
    endcase

    sat_d = sat_q || (score_d == SCORE_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_ARMED;
      cnt_q         <= 8'd0;
      score_q       <= 16'h0000;
      sat_q         <= 1'b0;
      hit_seen_q    <= 1'b0;
      prev_origin_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_q       <= score_d;
      sat_q         <= sat_d;
      hit_seen_q    <= hit_seen_d;
      prev_origin_q <= prev_origin_d;
    end
  end

  assign score_bcd = score_q;
  assign hit_pulse = (state_q == S_INCR);
  assign armed     = (state_q == S_ARMED);
  assign saturated = sat_q;

endmodule

// File: tb/tb_hit_score_counter.sv
// Directed bench for hit_score_counter: u2 runs with a 2-frame cooldown, u0 with none (used for the saturation run).
module tb_hit_score_counter;

  logic        clk = 1'b0;
  logic        reset2, reset0, collision;
  logic [31:0] pxl_x, pxl_y;
  logic [15:0] score2, score0;
  logic        pulse2, pulse0, sat2, sat0, armed2, armed0;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          armed_lo = 0;

  always #5 clk = ~clk;

  hit_score_counter #(.COOLDOWN_FRAMES(2)) u2 (
    .clk(clk), .reset(reset2), .collision(collision), .pxl_x(pxl_x), .pxl_y(pxl_y),
    .score_bcd(score2), .hit_pulse(pulse2), .saturated(sat2), .armed(armed2)
  );

  hit_score_counter #(.COOLDOWN_FRAMES(0)) u0 (
    .clk(clk), .reset(reset0), .collision(collision), .pxl_x(pxl_x), .pxl_y(pxl_y),
    .score_bcd(score0), .hit_pulse(pulse0), .saturated(sat0), .armed(armed0)
  );

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chkn(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pixel cycle on row 0; outputs are observed 1 time unit after the edge.
  task automatic cyc(input logic [31:0] x, input logic c);
    pxl_x     = x;
    pxl_y     = 32'd0;
    collision = c;
    @(posedge clk);
    #1;
    if (pulse2) pulses++;
    if (!armed2) armed_lo++;
  endtask

  task automatic body(input int start, input int len, input int cidx, input logic call);
    for (int i = start; i < len; i++) cyc(32'(i), call || (i == cidx));
  endtask

  task automatic frame(input int len, input int cidx, input logic call);
    cyc(32'd0, call || (cidx == 0));
    body(1, len, cidx, call);
  endtask

  task automatic rst2();
    reset2 = 1'b1;
    cyc(32'd5, 1'b0);
    reset2 = 1'b0;
  endtask

  task automatic pair0();
    cyc(32'd0, 1'b1);
    cyc(32'd1, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset2 = 1'b1;
    reset0 = 1'b1;
    collision = 1'b0;
    pxl_x = 32'd5;
    pxl_y = 32'd0;
    cyc(32'd5, 1'b0);
    cyc(32'd5, 1'b0);
    chk16("rst_score", score2, 16'h0000);
    chk1("rst_pulse", pulse2, 1'b0);
    chk1("rst_sat", sat2, 1'b0);
    chk1("rst_armed", armed2, 1'b1);
    reset2 = 1'b0;

    // Idle frames: nothing counted, never leaves ARMED.
    pulses = 0;
    armed_lo = 0;
    repeat (3) frame(8, -1, 1'b0);
    chkn("t1_pulses", pulses, 0);
    chkn("t1_armed_lo", armed_lo, 0);
    chk16("t1_score", score2, 16'h0000);

    // Single collision pixel in frame 1, then two-sof cooldown.
    rst2();
    frame(8, -1, 1'b0);
    frame(8, 3, 1'b0);
    cyc(32'd0, 1'b0);
    chk1("t2_pulse", pulse2, 1'b1);
    chk1("t2_armed_incr", armed2, 1'b0);
    cyc(32'd1, 1'b0);
    chk1("t2_pulse_off", pulse2, 1'b0);
    chk16("t2_score", score2, 16'h0001);
    body(2, 8, -1, 1'b0);
    cyc(32'd0, 1'b0);
    chk1("t2_cool1", armed2, 1'b0);
    body(1, 8, -1, 1'b0);
    cyc(32'd0, 1'b0);
    chk1("t2_rearm", armed2, 1'b1);
    pulses = 0;
    body(1, 8, -1, 1'b0);
    frame(8, -1, 1'b0);
    chkn("t2_no_extra", pulses, 0);
    chk16("t2_score_hold", score2, 16'h0001);

    // Continuous overlap for 9 frames: counted at the ends of frames 1, 4, 7.
    rst2();
    frame(8, -1, 1'b0);
    pulses = 0;
    repeat (9) frame(8, -1, 1'b1);
    frame(8, -1, 1'b0);
    frame(8, -1, 1'b0);
    chkn("t3_pulses", pulses, 3);
    chk16("t3_score", score2, 16'h0003);
    chk1("t3_armed", armed2, 1'b1);

    // Collision only on the sof cycle that opens frame 2.
    rst2();
    frame(8, -1, 1'b0);
    frame(8, -1, 1'b0);
    cyc(32'd0, 1'b1);
    chk1("t4_sof_coll", pulse2, 1'b0);
    body(1, 8, -1, 1'b0);
    cyc(32'd0, 1'b0);
    chk1("t4_pulse", pulse2, 1'b1);
    cyc(32'd1, 1'b0);
    chk16("t4_score", score2, 16'h0001);

    // Reset while in COOL.
    body(2, 8, -1, 1'b0);
    reset2 = 1'b1;
    cyc(32'd3, 1'b0);
    chk16("t6_cool_score", score2, 16'h0000);
    chk1("t6_cool_armed", armed2, 1'b1);
    chk1("t6_cool_pulse", pulse2, 1'b0);
    chk1("t6_cool_sat", sat2, 1'b0);
    reset2 = 1'b0;

    // Reset in the INCR cycle: the pending increment is dropped.
    frame(8, -1, 1'b0);
    frame(8, 2, 1'b0);
    cyc(32'd0, 1'b0);
    chk1("t6_incr", pulse2, 1'b1);
    reset2 = 1'b1;
    cyc(32'd1, 1'b0);
    chk16("t6_incr_score", score2, 16'h0000);
    chk1("t6_incr_armed", armed2, 1'b1);
    chk1("t6_incr_pulse", pulse2, 1'b0);
    chk1("t6_incr_sat", sat2, 1'b0);
    reset2 = 1'b0;
    cyc(32'd2, 1'b0);
    chk16("t6_after_score", score2, 16'h0000);

    // Zero cooldown, 2-cycle frames with constant overlap: one hit per frame.
    reset2 = 1'b1;
    reset0 = 1'b0;
    cyc(32'd5, 1'b1);
    repeat (999) pair0();
    chk16("t5_0999", score0, 16'h0999);
    pair0();
    chk16("t5_1000", score0, 16'h1000);
    chk1("t5_sat_1000", sat0, 1'b0);
    repeat (8998) pair0();
    chk16("t5_9998", score0, 16'h9998);
    chk1("t5_sat_9998", sat0, 1'b0);
    pair0();
    chk16("t5_9999", score0, 16'h9999);
    chk1("t5_sat_9999", sat0, 1'b1);
    cyc(32'd0, 1'b1);
    chk1("t5_pulse_sat", pulse0, 1'b1);
    cyc(32'd1, 1'b1);
    chk16("t5_hold", score0, 16'h9999);
    chk1("t5_sat_hold", sat0, 1'b1);
    chk1("t5_pulse_done", pulse0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
